// File: rtl/axis_to_mii.sv
// rtl/axis_to_mii.sv - AXI-Stream byte frames to MII nibbles with preamble, pad, FCS and IPG
module axis_to_mii #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IPG_BYTES      = 12,
    parameter int ADD_PAD        = 1,
    parameter int ADD_FCS        = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] saxis_tdata,
    input  logic       saxis_tvalid,
    output logic       saxis_tready,
    input  logic       saxis_tlast,
    input  logic       saxis_tuser,
    output logic [3:0] mii_d,
    output logic       mii_en,
    output logic       mii_er
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DISCARD, IPG} state_t;

    localparam logic [4:0] PRE_LAST = 5'(2 * PREAMBLE_BYTES - 1);
    localparam logic [4:0] IPG_LAST = 5'(2 * IPG_BYTES - 1);

    state_t      state, state_n;
    logic [4:0]  nib_cnt, nib_cnt_n;
    logic [5:0]  byte_cnt, byte_cnt_n;
    logic [31:0] crc, crc_n, fcs_word;
    logic [7:0]  hold_data, hold_data_n;
    logic        hold_last, hold_last_n, hold_err, hold_err_n;
    logic        phase, phase_n, underrun, underrun_n;
    logic [3:0]  d_n;
    logic        en_n, er_n, ready_c;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign fcs_word     = ~crc;
    assign saxis_tready = ready_c && !reset;

    always_comb begin
        state_n     = state;
        nib_cnt_n   = nib_cnt;
        byte_cnt_n  = byte_cnt;
        crc_n       = crc;
        hold_data_n = hold_data;
        hold_last_n = hold_last;
        hold_err_n  = hold_err;
        phase_n     = phase;
        underrun_n  = underrun;
        d_n         = 4'h0;
        en_n        = 1'b0;
        er_n        = 1'b0;
        ready_c     = 1'b0;
        case (state)
            IDLE: begin
                crc_n      = 32'hFFFFFFFF;
                byte_cnt_n = 6'd0;
                nib_cnt_n  = 5'd0;
                phase_n    = 1'b0;
                underrun_n = 1'b0;
                if (saxis_tvalid) state_n = PREAMBLE;
            end
            PREAMBLE: begin
                en_n      = 1'b1;
                d_n       = 4'h5;
                nib_cnt_n = nib_cnt + 5'd1;
                if (nib_cnt == PRE_LAST) begin
                    nib_cnt_n = 5'd0;
                    state_n   = SFD;
                end
            end
            SFD: begin
                en_n = 1'b1;
                if (!phase) begin
                    d_n     = 4'h5;
                    phase_n = 1'b1;
                end else begin
                    d_n     = 4'hD;
                    ready_c = 1'b1;
                    phase_n = 1'b0;
                    state_n = DATA;
                    if (saxis_tvalid) begin
                        hold_data_n = saxis_tdata;
                        hold_last_n = saxis_tlast;
                        hold_err_n  = saxis_tuser;
                        crc_n       = crc_byte(crc, saxis_tdata);
                        byte_cnt_n  = (byte_cnt == 6'd60) ? 6'd60 : byte_cnt + 6'd1;
                    end else begin
                        underrun_n = 1'b1;
                    end
                end
            end
            DATA: begin
                en_n = 1'b1;
                // After an underrun the two DATA cycles become the error-marker nibbles.
                if (underrun) begin
                    er_n    = 1'b1;
                    phase_n = ~phase;
                    if (phase) begin
                        underrun_n = 1'b0;
                        state_n    = DISCARD;
                    end
                end else if (!phase) begin
                    d_n     = hold_data[3:0];
                    er_n    = hold_err;
                    phase_n = 1'b1;
                end else begin
                    d_n     = hold_data[7:4];
                    er_n    = hold_err;
                    phase_n = 1'b0;
                    if (hold_last) begin
                        nib_cnt_n = 5'd0;
                        if (ADD_PAD != 0 && byte_cnt < 6'd60) state_n = PAD;
                        else if (ADD_FCS != 0)                state_n = FCS;
                        else                                  state_n = IPG;
                    end else begin
                        ready_c = 1'b1;
                        if (saxis_tvalid) begin
                            hold_data_n = saxis_tdata;
                            hold_last_n = saxis_tlast;
                            hold_err_n  = saxis_tuser;
                            crc_n       = crc_byte(crc, saxis_tdata);
                            byte_cnt_n  = (byte_cnt == 6'd60) ? 6'd60 : byte_cnt + 6'd1;
                        end else begin
                            underrun_n = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                en_n    = 1'b1;
                phase_n = ~phase;
                if (phase) begin
                    crc_n      = crc_byte(crc, 8'h00);
                    byte_cnt_n = byte_cnt + 6'd1;
                    if (byte_cnt == 6'd59) state_n = (ADD_FCS != 0) ? FCS : IPG;
                end
            end
            FCS: begin
                en_n      = 1'b1;
                d_n       = fcs_word[{nib_cnt[2:0], 2'b00} +: 4];
                nib_cnt_n = nib_cnt + 5'd1;
                if (nib_cnt == 5'd7) begin
                    nib_cnt_n = 5'd0;
                    state_n   = IPG;
                end
            end
            DISCARD: begin
                ready_c = 1'b1;
                if (saxis_tvalid && saxis_tlast) begin
                    nib_cnt_n = 5'd0;
                    state_n   = IPG;
                end
            end
            IPG: begin
                nib_cnt_n = nib_cnt + 5'd1;
                if (nib_cnt == IPG_LAST) begin
                    nib_cnt_n = 5'd0;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            nib_cnt   <= 5'd0;
            byte_cnt  <= 6'd0;
            crc       <= 32'hFFFFFFFF;
            hold_data <= 8'h00;
            hold_last <= 1'b0;
            hold_err  <= 1'b0;
            phase     <= 1'b0;
            underrun  <= 1'b0;
            mii_d     <= 4'h0;
            mii_en    <= 1'b0;
            mii_er    <= 1'b0;
        end else begin
            state     <= state_n;
            nib_cnt   <= nib_cnt_n;
            byte_cnt  <= byte_cnt_n;
            crc       <= crc_n;
            hold_data <= hold_data_n;
            hold_last <= hold_last_n;
            hold_err  <= hold_err_n;
            phase     <= phase_n;
            underrun  <= underrun_n;
            mii_d     <= d_n;
            mii_en    <= en_n;
            mii_er    <= er_n;
        end
    end
endmodule

// File: tb/tb_axis_to_mii.sv
// tb/tb_axis_to_mii.sv - scoreboard bench for axis_to_mii over three parameter sets
module tb_axis_to_mii;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [7:0]  tdata_v  [3];
    logic        tvalid_v [3];
    logic        tlast_v  [3];
    logic        tuser_v  [3];
    logic [2:0]  tready_v, en_v, er_v;
    logic [11:0] d_v;

    axis_to_mii #(.ADD_PAD(0), .ADD_FCS(0)) u0 (
        .clock(clock), .reset(reset),
        .saxis_tdata(tdata_v[0]), .saxis_tvalid(tvalid_v[0]), .saxis_tready(tready_v[0]),
        .saxis_tlast(tlast_v[0]), .saxis_tuser(tuser_v[0]),
        .mii_d(d_v[3:0]), .mii_en(en_v[0]), .mii_er(er_v[0]));

    axis_to_mii #(.ADD_PAD(0), .ADD_FCS(1)) u1 (
        .clock(clock), .reset(reset),
        .saxis_tdata(tdata_v[1]), .saxis_tvalid(tvalid_v[1]), .saxis_tready(tready_v[1]),
        .saxis_tlast(tlast_v[1]), .saxis_tuser(tuser_v[1]),
        .mii_d(d_v[7:4]), .mii_en(en_v[1]), .mii_er(er_v[1]));

    axis_to_mii u2 (
        .clock(clock), .reset(reset),
        .saxis_tdata(tdata_v[2]), .saxis_tvalid(tvalid_v[2]), .saxis_tready(tready_v[2]),
        .saxis_tlast(tlast_v[2]), .saxis_tuser(tuser_v[2]),
        .mii_d(d_v[11:8]), .mii_en(en_v[2]), .mii_er(er_v[2]));

    typedef struct {
        bit         gap;
        int         gmin;
        int         gmax;
        bit         er;
        logic [3:0] d;
    } exp_t;

    exp_t       q[$];
    logic [7:0] frame[$];
    int         checks = 0;
    int         errors = 0;
    int         gap_cnt = 0;
    int         cur = 0;
    bit         mon_on = 1'b0;
    localparam int BIG = 1000000;

    function automatic void push_nib(input bit er, input logic [3:0] d);
        exp_t e;
        e.gap = 1'b0; e.gmin = 0; e.gmax = 0; e.er = er; e.d = d;
        q.push_back(e);
    endfunction

    function automatic void push_byte(input bit er, input logic [7:0] b);
        push_nib(er, b[3:0]);
        push_nib(er, b[7:4]);
    endfunction

    function automatic void push_gap(input int gmin, input int gmax);
        exp_t e;
        e.gap = 1'b1; e.gmin = gmin; e.gmax = gmax; e.er = 1'b0; e.d = 4'h0;
        q.push_back(e);
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Expected line activity for the bytes in frame; gmin < 0 means no leading gap record.
    task automatic build(input int err_idx, input bit pad, input bit fcs, input int gmin, input int gmax);
        logic [31:0] c;
        int n;
        if (gmin >= 0) push_gap(gmin, gmax);
        for (int i = 0; i < 15; i++) push_nib(1'b0, 4'h5);
        push_nib(1'b0, 4'hD);
        c = 32'hFFFFFFFF;
        n = 0;
        foreach (frame[i]) begin
            push_byte(i == err_idx, frame[i]);
            c = crc_upd(c, frame[i]);
            n++;
        end
        if (pad) while (n < 60) begin
            push_byte(1'b0, 8'h00);
            c = crc_upd(c, 8'h00);
            n++;
        end
        if (fcs) begin
            c = ~c;
            for (int k = 0; k < 8; k++) push_nib(1'b0, c[4*k +: 4]);
        end
    endtask

    function automatic void check_nib();
        exp_t e;
        if (q.size() == 0) begin
            if (en_v[cur]) begin
                checks++; errors++;
                $display("FAIL unexpected_en inst=%0d got mii_en=1 d=%h, required idle line", cur, d_v[cur*4 +: 4]);
            end
            return;
        end
        e = q.pop_front();
        checks++;
        if (en_v[cur] !== 1'b1 || er_v[cur] !== e.er || d_v[cur*4 +: 4] !== e.d) begin
            errors++;
            $display("FAIL nibble inst=%0d got en=%b er=%b d=%h, required en=1 er=%b d=%h",
                     cur, en_v[cur], er_v[cur], d_v[cur*4 +: 4], e.er, e.d);
        end
    endfunction

    always @(negedge clock) begin
        if (mon_on) begin
            if (q.size() != 0 && q[0].gap) begin
                if (en_v[cur]) begin
                    checks++;
                    if (gap_cnt < q[0].gmin || gap_cnt > q[0].gmax) begin
                        errors++;
                        $display("FAIL idle_gap inst=%0d got %0d idle cycles, required %0d..%0d",
                                 cur, gap_cnt, q[0].gmin, q[0].gmax);
                    end
                    void'(q.pop_front());
                    gap_cnt = 0;
                    check_nib();
                end else begin
                    gap_cnt++;
                    checks++;
                    if (er_v[cur] !== 1'b0) begin
                        errors++;
                        $display("FAIL er_while_idle inst=%0d got mii_er=%b, required 0", cur, er_v[cur]);
                    end
                end
            end else begin
                check_nib();
            end
        end
    end

    task automatic put(input logic [7:0] b, input bit last, input bit user);
        int t;
        tdata_v[cur] = b; tlast_v[cur] = last; tuser_v[cur] = user; tvalid_v[cur] = 1'b1;
        t = 0;
        while (1) begin
            @(negedge clock);
            if (tready_v[cur]) break;
            t++;
            if (t > 2000) begin
                checks++; errors++;
                $display("FAIL put_timeout inst=%0d byte=%h got no tready, required tready within 2000 cycles", cur, b);
                tvalid_v[cur] = 1'b0;
                return;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int err_idx);
        for (int i = 0; i < frame.size(); i++) put(frame[i], i == frame.size() - 1, i == err_idx);
    endtask

    task automatic start_inst(input int i);
        cur = i; q.delete(); gap_cnt = 0; mon_on = 1'b1;
    endtask

    task automatic finish_inst();
        int t;
        tvalid_v[cur] = 1'b0;
        push_gap(25, BIG);
        t = 0;
        while (q.size() > 1 && t < 5000) begin
            @(posedge clock);
            t++;
        end
        repeat (30) @(posedge clock);
        #1;
        checks++;
        if (q.size() != 1 || gap_cnt < 25) begin
            errors++;
            $display("FAIL drain inst=%0d got queue=%0d idle=%0d, required queue=1 idle>=25", cur, q.size(), gap_cnt);
        end
        mon_on = 1'b0; q.delete(); gap_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete, required finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 3; i++) begin
            tdata_v[i] = 8'h00; tvalid_v[i] = 1'b1; tlast_v[i] = 1'b0; tuser_v[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (en_v[i] !== 1'b0 || tready_v[i] !== 1'b0 || er_v[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_hold inst=%0d got en=%b tready=%b er=%b, required 0 0 0",
                             i, en_v[i], tready_v[i], er_v[i]);
                end
            end
        end
        for (int i = 0; i < 3; i++) tvalid_v[i] = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // no pad, no FCS: single byte, then a back-to-back second frame
        start_inst(0);
        frame = '{8'hA5};
        build(-1, 1'b0, 1'b0, 0, BIG);
        send(-1);
        frame = '{8'h3C, 8'hC3};
        build(-1, 1'b0, 1'b0, 25, 25);
        send(-1);
        finish_inst();

        // FCS only: check value against the well-known "123456789" CRC
        start_inst(1);
        frame = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        build(-1, 1'b0, 1'b0, 0, BIG);
        push_nib(1'b0, 4'h6); push_nib(1'b0, 4'h2); push_nib(1'b0, 4'h9); push_nib(1'b0, 4'h3);
        push_nib(1'b0, 4'h4); push_nib(1'b0, 4'hF); push_nib(1'b0, 4'hB); push_nib(1'b0, 4'hC);
        send(-1);
        finish_inst();

        // defaults: short padded frame, long unpadded frame, underrun, tuser
        start_inst(2);
        frame = '{8'hBA, 8'hDC};
        build(-1, 1'b1, 1'b1, 0, BIG);
        send(-1);
        frame.delete();
        for (int i = 0; i < 70; i++) frame.push_back(8'(i * 7 + 3));
        build(-1, 1'b1, 1'b1, 25, 25);
        send(-1);

        frame = '{8'hA1, 8'hA2, 8'hA3};
        build(-1, 1'b0, 1'b0, 25, 25);
        push_nib(1'b1, 4'h0);
        push_nib(1'b1, 4'h0);
        push_gap(25, 1000);
        put(8'hA1, 1'b0, 1'b0);
        put(8'hA2, 1'b0, 1'b0);
        put(8'hA3, 1'b0, 1'b0);
        tvalid_v[2] = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        for (int i = 4; i <= 10; i++) put(8'(8'hA0 + i), i == 10, 1'b0);

        frame = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        build(1, 1'b1, 1'b1, -1, 0);
        send(1);
        finish_inst();

        // reset in the middle of DATA
        cur = 2;
        tdata_v[2] = 8'h77; tlast_v[2] = 1'b0; tuser_v[2] = 1'b0; tvalid_v[2] = 1'b1;
        t = 0;
        while (1) begin
            @(negedge clock);
            if (en_v[2] || t > 200) break;
            t++;
        end
        checks++;
        if (!en_v[2]) begin
            errors++;
            $display("FAIL reset_frame_start got mii_en=0, required frame start within 200 cycles");
        end
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (en_v[2] !== 1'b0 || er_v[2] !== 1'b0 || tready_v[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_truncate got en=%b er=%b tready=%b, required 0 0 0", en_v[2], er_v[2], tready_v[2]);
        end
        tvalid_v[2] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clock);
            checks++;
            if (en_v[2] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle got mii_en=%b, required 0", en_v[2]);
            end
        end
        @(posedge clock);
        #1;
        start_inst(2);
        frame = '{8'h01, 8'h02, 8'h03};
        build(-1, 1'b1, 1'b1, 0, BIG);
        send(-1);
        finish_inst();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
